// File: rtl/inst_fetch_queue.sv
// Fetch stage: PC generation, in-order instruction memory requests and a DEPTH-entry {pc, instr} queue to decode.
// Optional opcode predecode per entry is enabled by defining FQ_PREDECODE_EN.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4,
  output logic [2:0]  dec_imm_src
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [31:0]   pc;
  logic [31:0]   rsp_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0]   used;
  logic          accept;
  logic          pop;
  logic          drop;
  logic          push;
  logic [31:0]   redirect_base;

  // Queue occupancy plus live (non-discarded) requests bounds new requests.
  assign used           = {1'b0, count} + {1'b0, CW'(inflight - discard)};
  assign imem_req_valid = rst_n && !redirect_valid && (used < DEPTH_W);
  assign imem_addr      = pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign dec_valid      = (count != '0);
  assign pop            = dec_valid && dec_ready;
  assign drop           = (discard != '0);
  assign push           = imem_rsp_valid && !redirect_valid && !drop;
  assign redirect_base  = {redirect_pc[31:2], 2'b00};

  assign dec_pc       = pc_mem[head];
  assign dec_instr    = instr_mem[head];
  assign dec_pc_plus4 = dec_pc + 32'd4;

`ifdef FQ_PREDECODE_EN
  logic [2:0] src_mem [DEPTH];
  logic [2:0] rsp_src;

  // Immediate format from the opcode of the returning instruction.
  always_comb begin
    rsp_src = 3'b000;
    case (imem_rsp_data[6:0])
      7'b0100011:             rsp_src = 3'b001;
      7'b1100011:             rsp_src = 3'b010;
      7'b0110111, 7'b0010111: rsp_src = 3'b011;
      7'b1101111:             rsp_src = 3'b100;
      default:                rsp_src = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) src_mem[i] <= 3'b000;
    end else if (push) begin
      src_mem[tail] <= rsp_src;
    end
  end

  assign dec_imm_src = src_mem[head];
`else
  assign dec_imm_src = 3'b000;
`endif

  // Fetch and queue state; redirect overrides every other update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc       <= RESET_PC;
      rsp_pc   <= RESET_PC;
      count    <= '0;
      inflight <= '0;
      discard  <= '0;
      head     <= '0;
      tail     <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      pc       <= redirect_base;
      rsp_pc   <= redirect_base;
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      inflight <= inflight - CW'(imem_rsp_valid);
      discard  <= inflight - CW'(imem_rsp_valid);
    end else begin
      if (accept) pc <= pc + 32'd4;
      inflight <= inflight + CW'(accept) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && drop) discard <= discard - CW'(1);
      if (push) begin
        pc_mem[tail]    <= rsp_pc;
        instr_mem[tail] <= imem_rsp_data;
        tail            <= tail + AW'(1);
        rsp_pc          <= rsp_pc + 32'd4;
      end
      if (pop) head <= head + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // The credit rule must make a push into a full queue impossible.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      assert (count < DEPTH_C) else $error("inst_fetch_queue: push into full queue");
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue: request-level reference model with a fixed-latency memory,
// plus directed sequences pinning latency, stall, redirect, wrap and predecode results.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;
  logic [2:0]  dec_imm_src;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr),
    .dec_pc(dec_pc), .dec_pc_plus4(dec_pc_plus4), .dec_imm_src(dec_imm_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; bit stale; } req_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic [31:0] plus4; logic [2:0] src; int cyc; } obs_t;

  req_t        outst[$];
  ent_t        fifo[$];
  obs_t        hs_log[$];
  logic [31:0] mpc;
  int          cyc;
  int          lat;
  bit          model_ok;
  bit          rst_drv;
  int          n_checks;
  int          n_fail;
  logic        obs_req_valid;
  logic        obs_dec_valid;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h400: mem_word = 32'h0050_0093;
      32'h404: mem_word = 32'h0011_2023;
      32'h408: mem_word = 32'h0020_8463;
      32'h40C: mem_word = 32'h0000_12B7;
      32'h410: mem_word = 32'h0080_006F;
      default: mem_word = addr;
    endcase
  endfunction

  function automatic logic [2:0] exp_src(input logic [31:0] instr);
    exp_src = 3'b000;
`ifdef FQ_PREDECODE_EN
    case (instr[6:0])
      7'b0100011:             exp_src = 3'b001;
      7'b1100011:             exp_src = 3'b010;
      7'b0110111, 7'b0010111: exp_src = 3'b011;
      7'b1101111:             exp_src = 3'b100;
      default:                exp_src = 3'b000;
    endcase
`endif
  endfunction

  function automatic int live_requests();
    int n = 0;
    foreach (outst[i]) if (!outst[i].stale) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs, compare against the model, then advance the model across the edge.
  task automatic step(input bit rdy, input bit drdy, input bit redir, input logic [31:0] rpc);
    bit   exp_rv;
    bit   acc;
    bit   rv;
    req_t r;
    @(negedge clk);
    rst_n          = rst_drv;
    imem_req_ready = rdy;
    dec_ready      = drdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    rv = rst_drv && (outst.size() != 0) && (outst[0].due == cyc);
    imem_rsp_valid = rv;
    imem_rsp_data  = rv ? mem_word(outst[0].addr) : $urandom;
    #1;
    exp_rv = rst_drv && !redir && ((fifo.size() + live_requests()) < DEPTH);
    obs_req_valid = imem_req_valid;
    obs_dec_valid = dec_valid;
    if (model_ok) begin
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("imem_addr", imem_addr, mpc);
      chk("dec_valid", 32'(dec_valid), 32'(fifo.size() != 0));
      if (fifo.size() != 0) begin
        chk("dec_pc", dec_pc, fifo[0].pc);
        chk("dec_instr", dec_instr, fifo[0].instr);
        chk("dec_pc_plus4", dec_pc_plus4, fifo[0].pc + 32'd4);
        chk("dec_imm_src", 32'(dec_imm_src), 32'(exp_src(fifo[0].instr)));
      end
    end
    if (rst_drv && dec_valid && drdy)
      hs_log.push_back('{pc: dec_pc, instr: dec_instr, plus4: dec_pc_plus4, src: dec_imm_src, cyc: cyc});
    if (!rst_drv) begin
      fifo.delete();
      outst.delete();
      mpc      = RESET_PC;
      model_ok = 1'b1;
    end else begin
      acc = exp_rv && rdy;
      if (fifo.size() != 0 && drdy) void'(fifo.pop_front());
      if (rv) begin
        r = outst.pop_front();
        if (!redir && !r.stale) fifo.push_back('{pc: r.addr, instr: imem_rsp_data});
      end
      if (acc) begin
        outst.push_back('{addr: mpc, due: cyc + lat, stale: 1'b0});
        mpc = mpc + 32'd4;
      end
      if (redir) begin
        foreach (outst[i]) outst[i].stale = 1'b1;
        fifo.delete();
        mpc = {rpc[31:2], 2'b00};
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst_drv = 1'b0;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    rst_drv = 1'b1;
  endtask

  initial begin
    int base;
    int start;
    logic [2:0] src_exp [5];
    n_checks = 0; n_fail = 0; cyc = 0; lat = 1; model_ok = 1'b0; rst_drv = 1'b0;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; dec_ready = 1'b0;

    // Reset values, sampled just after the reset edge.
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_dec_valid", 32'(dec_valid), 32'd0);
    chk("rst_dec_instr", dec_instr, 32'd0);
    chk("rst_dec_pc", dec_pc, 32'd0);
    rst_drv = 1'b1;

    // Free-running stream with a 1-cycle memory.
    base = hs_log.size(); start = cyc;
    repeat (30) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("first_latency", 32'(hs_log[base].cyc - start), 32'd2);
    for (int i = 0; i < 3; i++) begin
      chk("stream_pc", hs_log[base+i].pc, 32'(4*i));
      chk("stream_instr", hs_log[base+i].instr, 32'(4*i));
      chk("stream_plus4", hs_log[base+i].plus4, 32'(4*i+4));
    end

    // Decode stall fills exactly DEPTH entries, then drains in order.
    do_reset();
    repeat (20) step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("stall_req_valid", 32'(obs_req_valid), 32'd0);
    chk("stall_dec_valid", 32'(obs_dec_valid), 32'd1);
    chk("stall_depth", 32'(fifo.size()), 32'(DEPTH));
    base = hs_log.size();
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) chk("drain_pc", hs_log[base+i].pc, 32'(4*i));

    // 3-cycle memory: redirect with two requests outstanding.
    do_reset();
    lat = 3;
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    base = hs_log.size();
    step(1'b1, 1'b1, 1'b1, 32'h100);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_flush", 32'(obs_dec_valid), 32'd0);
    repeat (15) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_first_pc", hs_log[base].pc, 32'h100);

    // Unaligned redirect target and PC wrap.
    repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);
    lat = 1;
    step(1'b1, 1'b1, 1'b1, 32'h203);
    base = hs_log.size();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("align_pc", hs_log[base].pc, 32'h200);
    step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFF8);
    base = hs_log.size();
    repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("wrap_pc0", hs_log[base].pc, 32'hFFFF_FFF8);
    chk("wrap_pc1", hs_log[base+1].pc, 32'hFFFF_FFFC);
    chk("wrap_plus4", hs_log[base+1].plus4, 32'h0);
    chk("wrap_pc2", hs_log[base+2].pc, 32'h0);

    // Redirect coinciding with a response and a decode handshake.
    repeat (5) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h300);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("redir_same_cycle", 32'(obs_dec_valid), 32'd0);

    // Immediate-type predecode.
`ifdef FQ_PREDECODE_EN
    src_exp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100};
`else
    src_exp = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
`endif
    step(1'b1, 1'b1, 1'b1, 32'h400);
    base = hs_log.size();
    repeat (12) step(1'b1, 1'b1, 1'b0, 32'h0);
    chk("predec_instr", hs_log[base].instr, 32'h0050_0093);
    for (int i = 0; i < 5; i++) chk("predec_src", 32'(hs_log[base+i].src), 32'(src_exp[i]));

    // Random traffic; memory latency changes only once the memory is idle.
    for (int blk = 0; blk < 10; blk++) begin
      repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);
      lat = $urandom_range(1, 3);
      for (int n = 0; n < 200; n++) begin
        if ($urandom_range(0, 299) == 0) do_reset();
        step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 20) == 0, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
